sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single 8 MHz command port of the Apple IIe SDRAM controller between two requesters. Requester A is the serial-command FIFO path; requester B is a pattern/self-test engine. The block sits in the clk8M domain between the requesters and the controller's addr/din/aux/we/dout port. It sequences one access per slot, holds off new accesses until the SDRAM is ready, and routes read data back to the requester that issued the read.

## Interface
Parameters:
- READ_LATENCY, 1, clk8M cycles from the ISSUE cycle to valid sdram_dout; legal range 1..3.
- FAIR, 1, 1 = round-robin arbitration; 0 = A has fixed priority, with starvation relief for B.
- STARVE_LIMIT, 4, FAIR=0 only: number of consecutive A grants with B pending before B is forced; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- clk8M  in  1  system clock; also the controller's clkref.
- rst8M  in  1  synchronous active-high reset.
- sdram_ready  in  1  controller initialised; no grants while low.
- a_valid  in  1  A request pending.
- a_ready  out  1  A request accepted this cycle.
- a_we  in  1  A request is a write.
- a_addr  in  21  A byte address.
- a_din  in  8  A write data.
- a_aux  in  1  A aux select.
- a_rsp_valid  out  1  A read data valid, one-cycle pulse.
- a_rsp_data  out  16  A read data.
- b_* ports: identical to the a_* set, for requester B.
- sdram_we  out  1  controller write enable.
- sdram_addr  out  21  controller address.
- sdram_din  out  8  controller write data.
- sdram_aux  out  1  controller aux select.
- sdram_dout  in  16  controller read data.
- busy  out  1  access in flight (state is not IDLE).
- owner_b  out  1  owner of the access in flight or last issued; 0 = A, 1 = B.

## Operation
- FSM states:
  - IDLE: arbitration happens here.
  - ISSUE: exactly 1 cycle; the controller samples the command.
  - WAIT: READ_LATENCY cycles.
- IDLE with sdram_ready=1 and at least one valid:
  - The winner's ready is asserted combinationally that cycle; the loser's ready stays 0.
  - valid&&ready registers we/addr/din/aux onto sdram_* and sets owner_b. Next state is ISSUE.
- Arbitration:
  - Only one valid requester: it wins.
  - Both valid, FAIR=1: the requester not granted last wins. The last-grant pointer resets to B, so A wins first.
  - Both valid, FAIR=0: A wins unless starve_cnt == STARVE_LIMIT, in which case B wins.
  - starve_cnt (4 bits) increments on each A grant while b_valid=1. It clears on any B grant, and clears on any A grant while b_valid=0.
- ISSUE → WAIT. sdram_we returns to 0 on the ISSUE→WAIT edge. addr/din/aux keep their last values.
- WAIT: a down-counter is loaded with READ_LATENCY-1.
  - At count 0, if the access was a read: capture sdram_dout into the owner's rsp_data and pulse the owner's rsp_valid for the following cycle.
  - Writes produce no response.
  - Next state is IDLE.
- rsp_data holds its value until the next read for the same requester. There is no response back-pressure; requesters must accept the pulse.
- sdram_ready falling mid-access: the current access completes, including its response. IDLE then grants nothing until sdram_ready is high again.
- Reset values:
  - State IDLE; all ready, rsp_valid and sdram_we outputs 0.
  - sdram_addr=0, sdram_din=0, sdram_aux=0.
  - rsp_data=0, owner_b=0, starve_cnt=0, last-grant=B.
- Reset mid-access drops the in-flight response; no rsp_valid pulse follows.

## Timing
- Handshake at cycle T (IDLE). ISSUE is cycle T+1, with sdram_we valid for that cycle only. WAIT covers T+2..T+1+L. rsp_valid pulses in cycle T+2+L.
- Throughput is one access per L+2 cycles. The next handshake may occur in cycle T+2+L, the same cycle as the rsp pulse.
- ready never asserts outside IDLE, and never for both requesters in the same cycle.
- The request fields must be stable only in the handshake cycle.

## Structure
- Package sdram_arb_pkg contains:
  - the state enum (IDLE, ISSUE, WAIT);
  - a packed request struct {we, addr[20:0], din[7:0], aux};
  - the width constants ADDR_W=21, DIN_W=8, DOUT_W=16.
- No sub-module. The winner selection is a pure function in the package, so it can be unit-checked.

## Test plan
- Single A read at addr 0x00123, L=1, sdram_dout=0xBEEF in the capture cycle → a_ready at T, sdram_we=0 at T+1, a_rsp_valid=1 with a_rsp_data=0xBEEF at T+3, b_rsp_valid stays 0.
- Both requesters valid continuously, FAIR=1 → grant sequence A, B, A, B; each grant is 3 cycles apart at L=1; owner_b toggles.
- FAIR=0, STARVE_LIMIT=4, both valid → A granted 4 times, then B, then A again.
- A write to 0x1FFFFF with din 0xA5 and aux=1 → sdram_we=1 for exactly one cycle with those values; no rsp_valid.
- sdram_ready=0 with a_valid=1 → a_ready stays 0 and busy stays 0. sdram_ready dropped during WAIT → the current response still arrives, and there is no new grant.
- rst8M asserted during WAIT of a B read → next cycle is IDLE with all outputs at reset values, and no b_rsp_valid pulse.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types, widths and the winner-select function for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W = 21;
  localparam int DIN_W  = 8;
  localparam int DOUT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DIN_W-1:0]  din;
    logic              aux;
  } req_t;

  // Returns 1 when B should win. Single requester always wins; with both
  // pending, round-robin flips against the last grant, otherwise A wins
  // unless B has been starved out.
  function automatic logic pick_b(input logic a_valid, input logic b_valid,
                                  input logic fair, input logic last_b,
                                  input logic starved);
    if (a_valid && b_valid) return fair ? !last_b : starved;
    return b_valid;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester A/B handshakes plus the controller command/data port.
interface sdram_port_arbiter_if;

  logic                             sdram_ready;

  logic                             a_valid;
  logic                             a_ready;
  logic                             a_we;
  logic [sdram_arb_pkg::ADDR_W-1:0] a_addr;
  logic [sdram_arb_pkg::DIN_W-1:0]  a_din;
  logic                             a_aux;
  logic                             a_rsp_valid;
  logic [sdram_arb_pkg::DOUT_W-1:0] a_rsp_data;

  logic                             b_valid;
  logic                             b_ready;
  logic                             b_we;
  logic [sdram_arb_pkg::ADDR_W-1:0] b_addr;
  logic [sdram_arb_pkg::DIN_W-1:0]  b_din;
  logic                             b_aux;
  logic                             b_rsp_valid;
  logic [sdram_arb_pkg::DOUT_W-1:0] b_rsp_data;

  logic                             sdram_we;
  logic [sdram_arb_pkg::ADDR_W-1:0] sdram_addr;
  logic [sdram_arb_pkg::DIN_W-1:0]  sdram_din;
  logic                             sdram_aux;
  logic [sdram_arb_pkg::DOUT_W-1:0] sdram_dout;

  logic                             busy;
  logic                             owner_b;

  // Arbiter side.
  modport slave (
    input  sdram_ready,
    input  a_valid, a_we, a_addr, a_din, a_aux,
    output a_ready, a_rsp_valid, a_rsp_data,
    input  b_valid, b_we, b_addr, b_din, b_aux,
    output b_ready, b_rsp_valid, b_rsp_data,
    output sdram_we, sdram_addr, sdram_din, sdram_aux,
    input  sdram_dout,
    output busy, owner_b
  );

  // Requester / controller side.
  modport master (
    output sdram_ready,
    output a_valid, a_we, a_addr, a_din, a_aux,
    input  a_ready, a_rsp_valid, a_rsp_data,
    output b_valid, b_we, b_addr, b_din, b_aux,
    input  b_ready, b_rsp_valid, b_rsp_data,
    input  sdram_we, sdram_addr, sdram_din, sdram_aux,
    output sdram_dout,
    input  busy, owner_b
  );

endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for the single clk8M SDRAM command port: one access
// per IDLE->ISSUE->WAIT slot, read data steered back to the issuing requester.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1,   // 1..3
  parameter int FAIR         = 1,
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  logic                 clk8M,
  input  logic                 rst8M,
  sdram_port_arbiter_if.slave  bus
);

  localparam int CNT_W = 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              acc_rd_q, acc_rd_d;
  logic              owner_b_q, owner_b_d;
  logic              last_b_q, last_b_d;
  logic [3:0]        starve_q, starve_d;
  logic              a_rsp_valid_q, a_rsp_valid_d;
  logic              b_rsp_valid_q, b_rsp_valid_d;
  logic [DOUT_W-1:0] a_rsp_data_q, a_rsp_data_d;
  logic [DOUT_W-1:0] b_rsp_data_q, b_rsp_data_d;

  logic a_ready, b_ready, win_b, starved, grant;
  req_t a_req, b_req;

  assign a_req = {bus.a_we, bus.a_addr, bus.a_din, bus.a_aux};
  assign b_req = {bus.b_we, bus.b_addr, bus.b_din, bus.b_aux};

  // Arbitration, command capture, latency countdown and response steering.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    acc_rd_d      = acc_rd_q;
    owner_b_d     = owner_b_q;
    last_b_d      = last_b_q;
    starve_d      = starve_q;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_data_d  = a_rsp_data_q;
    b_rsp_data_d  = b_rsp_data_q;
    a_ready       = 1'b0;
    b_ready       = 1'b0;

    starved = (starve_q == 4'(STARVE_LIMIT));
    win_b   = pick_b(bus.a_valid, bus.b_valid, FAIR != 0, last_b_q, starved);
    // Reset gating keeps ready low while the registers are being cleared.
    grant   = bus.sdram_ready && (bus.a_valid || bus.b_valid) && !rst8M;

    case (state_q)
      IDLE: begin
        if (grant) begin
          a_ready   = !win_b;
          b_ready   = win_b;
          req_d     = win_b ? b_req : a_req;
          acc_rd_d  = win_b ? !bus.b_we : !bus.a_we;
          owner_b_d = win_b;
          last_b_d  = win_b;
          // Only consecutive A wins over a waiting B count toward starvation.
          if (win_b || !bus.b_valid) starve_d = 4'd0;
          else if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Write strobe lives for the ISSUE cycle only.
        req_d.we = 1'b0;
        cnt_d    = CNT_W'(READ_LATENCY - 1);
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (acc_rd_q) begin
            if (owner_b_q) begin
              b_rsp_valid_d = 1'b1;
              b_rsp_data_d  = bus.sdram_dout;
            end else begin
              a_rsp_valid_d = 1'b1;
              a_rsp_data_d  = bus.sdram_dout;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk8M) begin
    if (rst8M) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= '0;
      acc_rd_q      <= 1'b0;
      owner_b_q     <= 1'b0;
      last_b_q      <= 1'b1;
      starve_q      <= 4'd0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      acc_rd_q      <= acc_rd_d;
      owner_b_q     <= owner_b_d;
      last_b_q      <= last_b_d;
      starve_q      <= starve_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_data_q  <= b_rsp_data_d;
    end
  end

  assign bus.a_ready     = a_ready;
  assign bus.b_ready     = b_ready;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.a_rsp_data  = a_rsp_data_q;
  assign bus.b_rsp_data  = b_rsp_data_q;
  assign bus.sdram_we    = req_q.we;
  assign bus.sdram_addr  = req_q.addr;
  assign bus.sdram_din   = req_q.din;
  assign bus.sdram_aux   = req_q.aux;
  assign bus.busy        = (state_q != IDLE);
  assign bus.owner_b     = owner_b_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: a round-robin/L=1 instance and a fixed-priority/L=2 instance
// sharing clock and reset.
module tb_sdram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter_if fi ();
  sdram_port_arbiter_if pi ();

  sdram_port_arbiter #(.READ_LATENCY(1), .FAIR(1), .STARVE_LIMIT(4)) dut_f (
    .clk8M(clk), .rst8M(rst), .bus(fi.slave)
  );

  sdram_port_arbiter #(.READ_LATENCY(2), .FAIR(0), .STARVE_LIMIT(4)) dut_p (
    .clk8M(clk), .rst8M(rst), .bus(pi.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic       eb;
  logic [5:0] pseq;

  initial begin
    fi.sdram_ready = 1'b1; pi.sdram_ready = 1'b1;
    fi.a_valid = 0; fi.a_we = 0; fi.a_addr = '0; fi.a_din = '0; fi.a_aux = 0;
    fi.b_valid = 0; fi.b_we = 0; fi.b_addr = '0; fi.b_din = '0; fi.b_aux = 0;
    pi.a_valid = 0; pi.a_we = 0; pi.a_addr = '0; pi.a_din = '0; pi.a_aux = 0;
    pi.b_valid = 0; pi.b_we = 0; pi.b_addr = '0; pi.b_din = '0; pi.b_aux = 0;
    fi.sdram_dout = '0; pi.sdram_dout = '0;

    // Reset values, with A requesting during reset.
    fi.a_valid = 1;
    step(); step();
    chk("rst_a_ready",  32'(fi.a_ready), 0);
    chk("rst_busy",     32'(fi.busy), 0);
    chk("rst_we",       32'(fi.sdram_we), 0);
    chk("rst_addr",     32'(fi.sdram_addr), 0);
    chk("rst_din",      32'(fi.sdram_din), 0);
    chk("rst_aux",      32'(fi.sdram_aux), 0);
    chk("rst_owner",    32'(fi.owner_b), 0);
    chk("rst_a_rspv",   32'(fi.a_rsp_valid), 0);
    chk("rst_a_rspd",   32'(fi.a_rsp_data), 0);
    chk("rst_p_busy",   32'(pi.busy), 0);
    fi.a_valid = 0;
    rst = 0;

    // Single A read, L=1.
    fi.a_valid = 1; fi.a_we = 0; fi.a_addr = 21'h00123; #1;
    chk("rd_a_ready", 32'(fi.a_ready), 1);
    chk("rd_b_ready", 32'(fi.b_ready), 0);
    step();                                   // T+1 ISSUE
    fi.a_valid = 0; fi.sdram_dout = 16'hBEEF;
    chk("rd_we",    32'(fi.sdram_we), 0);
    chk("rd_addr",  32'(fi.sdram_addr), 'h00123);
    chk("rd_busy",  32'(fi.busy), 1);
    chk("rd_owner", 32'(fi.owner_b), 0);
    step();                                   // T+2 WAIT
    chk("rd_rspv_early", 32'(fi.a_rsp_valid), 0);
    step();                                   // T+3
    chk("rd_rspv",   32'(fi.a_rsp_valid), 1);
    chk("rd_rspd",   32'(fi.a_rsp_data), 'hBEEF);
    chk("rd_b_rspv", 32'(fi.b_rsp_valid), 0);
    chk("rd_idle",   32'(fi.busy), 0);
    fi.sdram_dout = 16'h0;
    step();
    chk("rd_pulse_end", 32'(fi.a_rsp_valid), 0);
    chk("rd_hold",      32'(fi.a_rsp_data), 'hBEEF);

    // A write at the top address.
    fi.a_valid = 1; fi.a_we = 1; fi.a_addr = 21'h1FFFFF; fi.a_din = 8'hA5; fi.a_aux = 1; #1;
    chk("wr_ready", 32'(fi.a_ready), 1);
    step();                                   // ISSUE
    fi.a_valid = 0; fi.a_we = 0; fi.a_addr = '0; fi.a_din = '0; fi.a_aux = 0;
    chk("wr_we",   32'(fi.sdram_we), 1);
    chk("wr_addr", 32'(fi.sdram_addr), 'h1FFFFF);
    chk("wr_din",  32'(fi.sdram_din), 'hA5);
    chk("wr_aux",  32'(fi.sdram_aux), 1);
    step();                                   // WAIT
    chk("wr_we_drop",  32'(fi.sdram_we), 0);
    chk("wr_addr_hold",32'(fi.sdram_addr), 'h1FFFFF);
    chk("wr_aux_hold", 32'(fi.sdram_aux), 1);
    step();
    chk("wr_no_a_rsp", 32'(fi.a_rsp_valid), 0);
    chk("wr_no_b_rsp", 32'(fi.b_rsp_valid), 0);
    chk("wr_rspd_keep",32'(fi.a_rsp_data), 'hBEEF);

    // Round-robin from reset: A, B, A, B, three cycles apart.
    rst = 1; step(); rst = 0;
    fi.a_valid = 1; fi.b_valid = 1; fi.a_addr = 21'h10; fi.b_addr = 21'h20; #1;
    for (int g = 0; g < 4; g++) begin
      eb = (g % 2) == 1;
      chk("rr_a_ready", 32'(fi.a_ready), 32'(!eb));
      chk("rr_b_ready", 32'(fi.b_ready), 32'(eb));
      if (g > 0) begin
        chk("rr_rspv", 32'(eb ? fi.a_rsp_valid : fi.b_rsp_valid), 1);
        chk("rr_rspd", 32'(eb ? fi.a_rsp_data : fi.b_rsp_data), 32'('h1000 + g - 1));
      end
      step();                                 // ISSUE
      chk("rr_owner",   32'(fi.owner_b), 32'(eb));
      chk("rr_noready", 32'(fi.a_ready | fi.b_ready), 0);
      chk("rr_addr",    32'(fi.sdram_addr), eb ? 'h20 : 'h10);
      fi.sdram_dout = 16'(32'h1000 + g);
      step(); step();
    end
    fi.a_valid = 0; fi.b_valid = 0; #1;
    chk("rr_last_rspv", 32'(fi.b_rsp_valid), 1);
    chk("rr_last_rspd", 32'(fi.b_rsp_data), 'h1003);
    chk("rr_last_arsp", 32'(fi.a_rsp_valid), 0);
    step();

    // sdram_ready low: no grant; dropped mid-access: response still arrives.
    fi.sdram_ready = 0; fi.a_valid = 1; fi.a_we = 0; fi.a_addr = 21'h77; #1;
    chk("nrdy_ready", 32'(fi.a_ready), 0);
    chk("nrdy_busy",  32'(fi.busy), 0);
    step();
    chk("nrdy_ready2", 32'(fi.a_ready), 0);
    chk("nrdy_busy2",  32'(fi.busy), 0);
    fi.sdram_ready = 1; #1;
    chk("nrdy_grant", 32'(fi.a_ready), 1);
    step();                                   // ISSUE
    fi.sdram_ready = 0; fi.sdram_dout = 16'h5A5A;
    step();                                   // WAIT
    chk("drop_busy", 32'(fi.busy), 1);
    step();
    chk("drop_rspv",  32'(fi.a_rsp_valid), 1);
    chk("drop_rspd",  32'(fi.a_rsp_data), 'h5A5A);
    chk("drop_noreq", 32'(fi.a_ready), 0);
    chk("drop_idle",  32'(fi.busy), 0);
    step();
    chk("drop_noreq2", 32'(fi.a_ready), 0);
    chk("drop_idle2",  32'(fi.busy), 0);
    fi.a_valid = 0; fi.sdram_ready = 1;

    // Reset during WAIT of a B read drops the response.
    fi.b_valid = 1; fi.b_we = 0; fi.b_addr = 21'h55; #1;
    chk("rst_b_grant", 32'(fi.b_ready), 1);
    step();                                   // ISSUE
    fi.sdram_dout = 16'hCAFE;
    chk("rst_b_owner", 32'(fi.owner_b), 1);
    step();                                   // WAIT
    rst = 1;
    step();
    chk("rstw_busy",  32'(fi.busy), 0);
    chk("rstw_brspv", 32'(fi.b_rsp_valid), 0);
    chk("rstw_bready",32'(fi.b_ready), 0);
    chk("rstw_owner", 32'(fi.owner_b), 0);
    chk("rstw_addr",  32'(fi.sdram_addr), 0);
    chk("rstw_brspd", 32'(fi.b_rsp_data), 0);
    chk("rstw_arspd", 32'(fi.a_rsp_data), 0);
    rst = 0; fi.b_valid = 0;
    step();
    chk("rstw_brspv2", 32'(fi.b_rsp_valid), 0);
    chk("rstw_busy2",  32'(fi.busy), 0);

    // Fixed priority with starvation relief, L=2: A,A,A,A,B,A four cycles apart.
    pseq = 6'b010000;
    pi.a_valid = 1; pi.b_valid = 1; pi.a_addr = 21'h100; pi.b_addr = 21'h200; #1;
    for (int g = 0; g < 6; g++) begin
      eb = pseq[g];
      chk("pr_a_ready", 32'(pi.a_ready), 32'(!eb));
      chk("pr_b_ready", 32'(pi.b_ready), 32'(eb));
      if (g > 0) begin
        chk("pr_rspv", 32'(pseq[g-1] ? pi.b_rsp_valid : pi.a_rsp_valid), 1);
        chk("pr_rspd", 32'(pseq[g-1] ? pi.b_rsp_data : pi.a_rsp_data), 32'('h2000 + g - 1));
      end
      step();                                 // ISSUE
      chk("pr_owner", 32'(pi.owner_b), 32'(eb));
      pi.sdram_dout = 16'(32'h2000 + g);
      step();                                 // first WAIT
      chk("pr_busy", 32'(pi.busy), 1);
      chk("pr_rsp_quiet", 32'(pi.a_rsp_valid | pi.b_rsp_valid), 0);
      step(); step();
    end
    pi.a_valid = 0; pi.b_valid = 0; #1;
    chk("pr_last_rspv", 32'(pi.a_rsp_valid), 1);
    chk("pr_last_rspd", 32'(pi.a_rsp_data), 'h2005);
    chk("pr_b_keep",    32'(pi.b_rsp_data), 'h2004);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
